prompt_stream_assembler: RTL and testbench
==========================================

PROMPT_STREAM_ASSEMBLER -- requirements
Module: prompt_stream_assembler

Interface
REQ-001 SHALL have parameter NUM_DOCS, default 8, meaning the number of candidate retrieved documents (2..16).
REQ-002 SHALL have parameter MAX_OUT_LEN, default 4096, meaning the output byte cap and truncation point.
REQ-003 SHALL have parameter LEN_W, default $clog2(MAX_OUT_LEN+1), meaning the width of the length counters.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to begin a prompt; sampled only in IDLE.
REQ-007 SHALL have port mode, input, 1 bit: 0 = query-first, 1 = context-first; latched at start.
REQ-008 SHALL have port doc_mask, input, NUM_DOCS bits: included documents; latched at start.
REQ-009 SHALL have ports q_valid/q_ready/q_last/q_data, 1/1/1/8 bits: query byte stream in.
REQ-010 SHALL have ports d_valid/d_ready/d_last/d_data, 1/1/1/8 bits: document byte stream in.
REQ-011 SHALL have port d_req_idx, output, $clog2(NUM_DOCS) bits: index of the document currently requested upstream.
REQ-012 SHALL have ports o_valid/o_ready/o_last/o_data, 1/1/1/8 bits: assembled prompt stream out.
REQ-013 SHALL have ports busy, done, truncated (output, 1 bit each) and out_length (output, LEN_W bits).

Function
REQ-014 SHALL use states IDLE, Q_PFX, Q_BODY, SEP, C_PFX, D_BODY, D_SEP, DONE.
REQ-015 In mode 0, the output SHALL be "Query: " + query + "\n\n" + "Context: " + doc0 + "\n\n" + doc1 ... for included docs in ascending index.
REQ-016 In mode 1, the output SHALL be "Context: " + docs (with "\n\n" between them) + "\n\n" + "Query: " + query.
REQ-017 If the latched doc_mask is 0, the block SHALL omit C_PFX, the docs and the joining SEP, so the output is "Query: " + query only.
REQ-018 D_SEP SHALL be emitted only when a higher-index included document remains; excluded docs are never requested.
REQ-019 Output SHALL be a single register stage; o_data/o_last SHALL stay stable while o_valid && !o_ready.
REQ-020 A byte SHALL be accepted when in_valid && in_ready, with in_ready = (body state) && (!o_valid || o_ready); the byte appears on o_data on the next cycle (1-cycle latency).
REQ-021 Body states SHALL leave on an accepted beat with last; query and docs are at least 1 byte.
REQ-022 Prefix and separator bytes SHALL be issued whenever the output register is free, one per cycle, with no bubbles when o_ready=1.
REQ-023 The emitted-byte counter SHALL saturate at MAX_OUT_LEN; the byte that fills the cap SHALL carry o_last=1 and set truncated.
REQ-024 After truncation, the FSM SHALL continue sequencing while holding o_valid=0, and SHALL consume and drop remaining input beats (in_ready=1) until the final input last, so upstream never stalls.
REQ-025 Without truncation, o_last SHALL mark the final byte of the query (mode 0) or of the last included doc / query (mode 1).
REQ-026 busy SHALL be high outside IDLE; start while busy SHALL be ignored.
REQ-027 In DONE, out_length SHALL be updated with the emitted count and done SHALL pulse for 1 cycle, then the FSM returns to IDLE.
REQ-028 out_length and truncated SHALL hold their values until the next start; truncated SHALL be cleared at start.

Reset
REQ-029 Reset SHALL force: state=IDLE, o_valid=0, o_last=0, o_data=0, q_ready=0, d_ready=0, d_req_idx=0, busy=0, done=0, truncated=0, out_length=0.
REQ-030 Reset asserted mid-prompt SHALL abort immediately with no further output beats; the partial prompt is discarded.

Structure
REQ-031 Package rag_aug_pkg SHALL hold: the state enum; the mode enum; byte-array constants QUERY_PFX ("Query: ", 7 bytes), CONTEXT_PFX ("Context: ", 9 bytes) and SEP (0x0A 0x0A); and their length constants.
REQ-032 The output register and handshake SHALL be a sub-module aug_out_stage; the rest SHALL be flat.

Verification
REQ-033 Mode 0, query "hi", doc_mask=0b101, doc0="A", doc2="BC", o_ready=1 -> output "Query: hi\n\nContext: A\n\nBC", last on 'C', out_length=25, done pulses once.
REQ-034 Mode 1, same inputs -> output "Context: A\n\nBC\n\nQuery: hi", out_length=25; d_req_idx takes only the values 0 and 2.
REQ-035 doc_mask=0, query "x" -> output "Query: x", out_length=8, d_valid is never consumed.
REQ-036 MAX_OUT_LEN=16, mode 0, query of 20 bytes -> 16 bytes out, last on byte 16, truncated=1, all 20 query bytes consumed, done pulses.
REQ-037 Random o_ready (50%) plus random input valids -> the byte sequence is identical to the o_ready=1 run, and o_data is stable during stalls.
REQ-038 rst_n pulled low on the 5th query byte -> all outputs at their reset values; a subsequent start produces a correct full prompt.

Source files
------------

// File: rtl/rag_aug_pkg.sv
// rag_aug_pkg
//   Shared definitions for the prompt stream assembler:
//   - state_e : sequencing states of the assembler FSM
//   - mode_e  : prompt ordering (query-first / context-first)
//   - QUERY_PFX, CONTEXT_PFX, SEP byte arrays and their lengths
//   - const_byte / const_last_idx : lookup helpers for the fixed text
package rag_aug_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_Q_PFX  = 3'd1,
    S_Q_BODY = 3'd2,
    S_SEP    = 3'd3,
    S_C_PFX  = 3'd4,
    S_D_BODY = 3'd5,
    S_D_SEP  = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  typedef enum logic {
    MODE_QUERY_FIRST   = 1'b0,
    MODE_CONTEXT_FIRST = 1'b1
  } mode_e;

  localparam int QUERY_PFX_LEN   = 7;
  localparam int CONTEXT_PFX_LEN = 9;
  localparam int SEP_LEN         = 2;

  // Element [LEN-1] holds the first character of each constant.
  localparam logic [QUERY_PFX_LEN-1:0][7:0]   QUERY_PFX   = "Query: ";
  localparam logic [CONTEXT_PFX_LEN-1:0][7:0] CONTEXT_PFX = "Context: ";
  localparam logic [SEP_LEN-1:0][7:0]         SEP         = 16'h0A0A;

  // Byte number idx (0 = first) of the fixed text emitted in state st.
  function automatic logic [7:0] const_byte(input state_e st, input logic [3:0] idx);
    logic [7:0] b;
    case (st)
      S_Q_PFX:         b = QUERY_PFX[3'(QUERY_PFX_LEN - 1) - idx[2:0]];
      S_C_PFX:         b = CONTEXT_PFX[4'(CONTEXT_PFX_LEN - 1) - idx];
      S_SEP, S_D_SEP:  b = SEP[~idx[0]];
      default:         b = 8'h00;
    endcase
    return b;
  endfunction

  // Index of the final byte of the fixed text emitted in state st.
  function automatic logic [3:0] const_last_idx(input state_e st);
    logic [3:0] n;
    case (st)
      S_Q_PFX:        n = 4'(QUERY_PFX_LEN - 1);
      S_C_PFX:        n = 4'(CONTEXT_PFX_LEN - 1);
      S_SEP, S_D_SEP: n = 4'(SEP_LEN - 1);
      default:        n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/aug_out_stage.sv
// aug_out_stage
//   Single register stage driving the assembled prompt stream.
//   Ports: clk, rst_n (async active-low)
//          push_i/data_i/last_i : byte to load (only when free_o is high)
//          ready_i              : downstream ready
//          valid_o/data_o/last_o: registered output beat, held while stalled
//          free_o               : register can accept a byte this cycle
module aug_out_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       last_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       last_o,
  output logic       free_o
);

  logic       valid_q;
  logic [7:0] data_q;
  logic       last_q;

  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

  // Output register: load on push, drop valid once the beat is taken; data/last only change on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
    end else if (push_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/prompt_stream_assembler.sv
// prompt_stream_assembler
//   Builds a RAG prompt byte stream from a query stream, a set of retrieved
//   document streams and fixed prefix/separator text.
//   Ports: clk, rst_n (async active-low)
//          start/mode/doc_mask       : begin a prompt (sampled in IDLE only)
//          q_valid/q_ready/q_last/q_data : query bytes in
//          d_valid/d_ready/d_last/d_data : document bytes in, d_req_idx selects doc
//          o_valid/o_ready/o_last/o_data : assembled prompt out
//          busy, done, truncated, out_length : status
module prompt_stream_assembler
  import rag_aug_pkg::*;
#(
  parameter int NUM_DOCS    = 8,
  parameter int MAX_OUT_LEN = 4096,
  parameter int LEN_W       = $clog2(MAX_OUT_LEN + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        mode,
  input  logic [NUM_DOCS-1:0]         doc_mask,
  input  logic                        q_valid,
  output logic                        q_ready,
  input  logic                        q_last,
  input  logic [7:0]                  q_data,
  input  logic                        d_valid,
  output logic                        d_ready,
  input  logic                        d_last,
  input  logic [7:0]                  d_data,
  output logic [$clog2(NUM_DOCS)-1:0] d_req_idx,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic                        o_last,
  output logic [7:0]                  o_data,
  output logic                        busy,
  output logic                        done,
  output logic                        truncated,
  output logic [LEN_W-1:0]            out_length
);

  localparam int IDX_W = $clog2(NUM_DOCS);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [NUM_DOCS-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [3:0]          pidx_q, pidx_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d, olen_q, olen_d;
  logic                trunc_q, trunc_d, done_q, done_d;

  logic [IDX_W-1:0] first_idx_s, next_idx_s;
  logic             has_next_s, free_s, const_st_s, step_s, beat_s, in_last_s;
  logic             final_s, emit_s, cap_s, push_s, plast_s;
  logic [7:0]       pdata_s;

  // Lowest included doc of the incoming mask, and next included doc above the current one.
  always_comb begin
    first_idx_s = '0;
    next_idx_s  = '0;
    has_next_s  = 1'b0;
    for (int i = NUM_DOCS - 1; i >= 0; i--) begin
      first_idx_s = doc_mask[i] ? IDX_W'(i) : first_idx_s;
      next_idx_s  = (mask_q[i] && (IDX_W'(i) > idx_q)) ? IDX_W'(i) : next_idx_s;
      has_next_s  = (mask_q[i] && (IDX_W'(i) > idx_q)) ? 1'b1 : has_next_s;
    end
  end

  // Once truncated, inputs are drained unconditionally so upstream never stalls.
  assign q_ready    = (state_q == S_Q_BODY) && (trunc_q || free_s);
  assign d_ready    = (state_q == S_D_BODY) && (trunc_q || free_s);
  assign const_st_s = (state_q == S_Q_PFX) || (state_q == S_SEP) ||
                      (state_q == S_C_PFX) || (state_q == S_D_SEP);
  assign step_s     = const_st_s && (trunc_q || free_s);
  assign beat_s     = (q_valid && q_ready) || (d_valid && d_ready);
  assign in_last_s  = (state_q == S_Q_BODY) ? q_last : d_last;
  // The body beat whose last flag ends the whole prompt.
  assign final_s    = ((state_q == S_Q_BODY) &&
                       ((mode_q == MODE_CONTEXT_FIRST) || (mask_q == '0))) ||
                      ((state_q == S_D_BODY) && !has_next_s &&
                       (mode_q == MODE_QUERY_FIRST));
  assign emit_s     = !trunc_q && (step_s || beat_s);
  assign cap_s      = emit_s && (cnt_q == LEN_W'(MAX_OUT_LEN - 1));
  assign push_s     = emit_s;
  assign plast_s    = cap_s || (beat_s && in_last_s && final_s);
  assign pdata_s    = const_st_s ? const_byte(state_q, pidx_q) :
                      ((state_q == S_Q_BODY) ? q_data : d_data);

  // Next-state sequencing of prefixes, bodies and separators.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    pidx_d  = pidx_q;
    cnt_d   = emit_s ? (cnt_q + LEN_W'(1)) : cnt_q;
    trunc_d = trunc_q || cap_s;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode_e'(mode);
          mask_d  = doc_mask;
          idx_d   = first_idx_s;
          pidx_d  = 4'd0;
          cnt_d   = '0;
          trunc_d = 1'b0;
          state_d = (mode && (doc_mask != '0)) ? S_C_PFX : S_Q_PFX;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_Q_PFX, S_SEP, S_C_PFX, S_D_SEP: begin
        if (step_s && (pidx_q == const_last_idx(state_q))) begin
          pidx_d = 4'd0;
          case (state_q)
            S_Q_PFX: state_d = S_Q_BODY;
            S_SEP:   state_d = (mode_q == MODE_QUERY_FIRST) ? S_C_PFX : S_Q_PFX;
            default: state_d = S_D_BODY;
          endcase
        end else if (step_s) begin
          pidx_d = pidx_q + 4'd1;
        end else begin
          pidx_d = pidx_q;
        end
      end
      S_Q_BODY: begin
        if (beat_s && q_last) begin
          state_d = final_s ? S_DONE : S_SEP;
        end else begin
          state_d = S_Q_BODY;
        end
      end
      S_D_BODY: begin
        if (beat_s && d_last && has_next_s) begin
          idx_d   = next_idx_s;
          state_d = S_D_SEP;
        end else if (beat_s && d_last) begin
          state_d = final_s ? S_DONE : S_SEP;
        end else begin
          state_d = S_D_BODY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
    olen_d = done_d ? cnt_d : olen_q;
  end

  // FSM and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_QUERY_FIRST;
      mask_q  <= '0;
      idx_q   <= '0;
      pidx_q  <= 4'd0;
      cnt_q   <= '0;
      olen_q  <= '0;
      trunc_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      pidx_q  <= pidx_d;
      cnt_q   <= cnt_d;
      olen_q  <= olen_d;
      trunc_q <= trunc_d;
      done_q  <= done_d;
    end
  end

  assign d_req_idx  = idx_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign truncated  = trunc_q;
  assign out_length = olen_q;

  aug_out_stage u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .data_i  (pdata_s),
    .last_i  (plast_s),
    .ready_i (o_ready),
    .valid_o (o_valid),
    .data_o  (o_data),
    .last_o  (o_last),
    .free_o  (free_s)
  );

endmodule

// File: tb/tb_prompt_stream_assembler.sv
// Scoreboard bench: expected prompt bytes are pushed when a prompt is started,
// a monitor pops and compares every accepted output beat. Instance A uses the
// default cap, instance B a 16-byte cap.
module tb_prompt_stream_assembler;

  localparam int ND = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sel   = 1'b0;
  logic          mode  = 1'b0;
  logic [ND-1:0] doc_mask = '0;
  logic          q_valid = 1'b0, q_last = 1'b0, d_valid = 1'b0, d_last = 1'b0;
  logic [7:0]    q_data = 8'h00, d_data = 8'h00;
  logic          o_ready = 1'b1;
  logic          start_a, start_b;

  logic       q_ready_a, d_ready_a, o_valid_a, o_last_a, busy_a, done_a, trunc_a;
  logic       q_ready_b, d_ready_b, o_valid_b, o_last_b, busy_b, done_b, trunc_b;
  logic [7:0] o_data_a, o_data_b;
  logic [2:0] idx_a, idx_b;
  logic [12:0] olen_a;
  logic [4:0]  olen_b;

  logic       q_ready_m, d_ready_m, o_valid_m, o_last_m, busy_m, done_m, trunc_m;
  logic [7:0] o_data_m;
  logic [2:0] idx_m;
  logic [12:0] olen_m;

  assign start_a   = start && !sel;
  assign start_b   = start && sel;
  assign q_ready_m = sel ? q_ready_b : q_ready_a;
  assign d_ready_m = sel ? d_ready_b : d_ready_a;
  assign o_valid_m = sel ? o_valid_b : o_valid_a;
  assign o_last_m  = sel ? o_last_b  : o_last_a;
  assign o_data_m  = sel ? o_data_b  : o_data_a;
  assign busy_m    = sel ? busy_b    : busy_a;
  assign done_m    = sel ? done_b    : done_a;
  assign trunc_m   = sel ? trunc_b   : trunc_a;
  assign idx_m     = sel ? idx_b     : idx_a;
  assign olen_m    = sel ? {8'd0, olen_b} : olen_a;

  prompt_stream_assembler #(.NUM_DOCS(ND), .MAX_OUT_LEN(4096)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode), .doc_mask(doc_mask),
    .q_valid(q_valid), .q_ready(q_ready_a), .q_last(q_last), .q_data(q_data),
    .d_valid(d_valid), .d_ready(d_ready_a), .d_last(d_last), .d_data(d_data),
    .d_req_idx(idx_a), .o_valid(o_valid_a), .o_ready(o_ready), .o_last(o_last_a),
    .o_data(o_data_a), .busy(busy_a), .done(done_a), .truncated(trunc_a),
    .out_length(olen_a)
  );

  prompt_stream_assembler #(.NUM_DOCS(ND), .MAX_OUT_LEN(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode), .doc_mask(doc_mask),
    .q_valid(q_valid), .q_ready(q_ready_b), .q_last(q_last), .q_data(q_data),
    .d_valid(d_valid), .d_ready(d_ready_b), .d_last(d_last), .d_data(d_data),
    .d_req_idx(idx_b), .o_valid(o_valid_b), .o_ready(o_ready), .o_last(o_last_b),
    .o_data(o_data_b), .busy(busy_b), .done(done_b), .truncated(trunc_b),
    .out_length(olen_b)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [8:0] sb[$];
  string docs [ND];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: compare every accepted output beat and output stability under stall.
  initial begin : monitor
    logic       stall;
    logic [8:0] held;
    logic [8:0] exp;
    stall = 1'b0;
    held  = 9'h000;
    forever begin
      @(negedge clk);
      if (done_m) done_cnt++;
      if (stall && o_valid_m) check("hold_stable", 64'({o_last_m, o_data_m}), 64'(held));
      if (o_valid_m && o_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_byte: got %02h expected no byte", o_data_m);
        end else begin
          exp = sb.pop_front();
          check("out_byte", 64'({o_last_m, o_data_m}), 64'(exp));
        end
      end
      stall = o_valid_m && !o_ready;
      held  = {o_last_m, o_data_m};
    end
  end

  task automatic check_reset_vals();
    @(negedge clk);
    check("rst_out", 64'({o_valid_m, o_last_m, o_data_m}), 64'd0);
    check("rst_ready", 64'({q_ready_m, d_ready_m, idx_m}), 64'd0);
    check("rst_status", 64'({busy_m, done_m, trunc_m, olen_m}), 64'd0);
  endtask

  task automatic run(input string name, input logic s, input logic md, input logic [ND-1:0] mask,
                     input string qs, input bit rnd, input int abort_at, input string exp_s,
                     input int exp_len, input logic exp_tr, input logic [ND-1:0] exp_seen,
                     input int exp_dcons);
    int q_ptr, q_cons, d_cons, cyc, done0, dl;
    int d_ptr [ND];
    bit got_done, aborted;
    logic q_acc, d_acc;
    logic [2:0] d_idx;
    logic [ND-1:0] seen;
    for (int i = 0; i < exp_s.len(); i++) sb.push_back({(i == exp_s.len() - 1), exp_s[i]});
    done0 = done_cnt;
    @(posedge clk); #1;
    sel = s; mode = md; doc_mask = mask; start = 1'b1;
    q_ptr = 0; q_cons = 0; d_cons = 0; seen = '0;
    for (int i = 0; i < ND; i++) d_ptr[i] = 0;
    @(posedge clk); #1;
    start = 1'b0;
    got_done = 1'b0; aborted = 1'b0; cyc = 0;
    while (!got_done && !aborted && cyc < 400) begin
      q_valid = (q_ptr < qs.len()) && (!rnd || ($urandom_range(0, 1) == 1));
      q_data  = (q_ptr < qs.len()) ? qs[q_ptr] : 8'h00;
      q_last  = (q_ptr == qs.len() - 1);
      d_idx   = idx_m;
      dl      = docs[d_idx].len();
      d_valid = (d_ptr[d_idx] < dl) && (!rnd || ($urandom_range(0, 1) == 1));
      d_data  = (d_ptr[d_idx] < dl) ? docs[d_idx][d_ptr[d_idx]] : 8'h00;
      d_last  = (d_ptr[d_idx] == dl - 1);
      o_ready = !rnd || ($urandom_range(0, 1) == 1);
      if (abort_at >= 0 && q_ptr == abort_at && q_valid) begin
        rst_n   = 1'b0;
        aborted = 1'b1;
      end else begin
        @(negedge clk);
        q_acc = q_valid && q_ready_m;
        d_acc = d_valid && d_ready_m;
        if (busy_m) seen[idx_m] = 1'b1;
        if (done_m) got_done = 1'b1;
        @(posedge clk); #1;
        if (q_acc) q_ptr++;
        if (d_acc) begin
          d_ptr[d_idx]++;
          d_cons++;
        end
        cyc++;
      end
    end
    q_valid = 1'b0; d_valid = 1'b0; o_ready = 1'b1;
    if (aborted) begin
      check_reset_vals();
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
    end else begin
      check({name, "_done_seen"}, 64'(got_done), 64'd1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
      check({name, "_done_once"}, 64'(done_cnt - done0), 64'd1);
      check({name, "_out_length"}, 64'(olen_m), 64'(exp_len));
      check({name, "_truncated"}, 64'(trunc_m), 64'(exp_tr));
      check({name, "_q_consumed"}, 64'(q_ptr), 64'(qs.len()));
      check({name, "_d_consumed"}, 64'(d_cons), 64'(exp_dcons));
      check({name, "_req_idx"}, 64'(seen), 64'(exp_seen));
      sb.delete();
    end
  endtask

  initial begin : stim
    docs[0] = "A";  docs[1] = "dd"; docs[2] = "BC"; docs[3] = "Z3";
    docs[4] = "Z4"; docs[5] = "Z5"; docs[6] = "Z6"; docs[7] = "z";
    repeat (3) @(posedge clk);
    check_reset_vals();
    @(posedge clk); #1 rst_n = 1'b1;
    run("m0", 1'b0, 1'b0, 8'b0000_0101, "hi", 1'b0, -1,
        "Query: hi\n\nContext: A\n\nBC", 25, 1'b0, 8'b0000_0101, 3);
    run("m1", 1'b0, 1'b1, 8'b0000_0101, "hi", 1'b0, -1,
        "Context: A\n\nBC\n\nQuery: hi", 25, 1'b0, 8'b0000_0101, 3);
    run("nodoc", 1'b0, 1'b0, 8'b0000_0000, "x", 1'b0, -1,
        "Query: x", 8, 1'b0, 8'b0000_0001, 0);
    run("trunc", 1'b1, 1'b0, 8'b0000_0000, "ABCDEFGHIJKLMNOPQRST", 1'b0, -1,
        "Query: ABCDEFGHI", 16, 1'b1, 8'b0000_0001, 0);
    run("untrunc", 1'b1, 1'b0, 8'b0000_0000, "ok", 1'b0, -1,
        "Query: ok", 9, 1'b0, 8'b0000_0001, 0);
    run("m0_rnd", 1'b0, 1'b0, 8'b0000_0101, "hi", 1'b1, -1,
        "Query: hi\n\nContext: A\n\nBC", 25, 1'b0, 8'b0000_0101, 3);
    run("m1_rnd", 1'b0, 1'b1, 8'b0000_0101, "hi", 1'b1, -1,
        "Context: A\n\nBC\n\nQuery: hi", 25, 1'b0, 8'b0000_0101, 3);
    run("m1_three", 1'b0, 1'b1, 8'b1000_0110, "q", 1'b1, -1,
        "Context: dd\n\nBC\n\nz\n\nQuery: q", 28, 1'b0, 8'b1000_0110, 5);
    run("abort", 1'b0, 1'b0, 8'b0000_0000, "abcdefgh", 1'b0, 4,
        "Query: abcdefgh", 15, 1'b0, 8'b0000_0001, 0);
    run("after_rst", 1'b0, 1'b0, 8'b0000_0101, "hi", 1'b0, -1,
        "Query: hi\n\nContext: A\n\nBC", 25, 1'b0, 8'b0000_0101, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
